// File: rtl/adc_spi_capture.sv
// adc_spi_capture: SPI master front-end for a 12-bit ADC (16-clock frames).
// Generates chip select and serial clock, shifts in each conversion, and
// hands sample[11:4] to a downstream byte FIFO with a stretched push pulse
// long enough to be seen exactly once by the FIFO's divided clock.
module adc_spi_capture #(
  parameter int CLK_DIV    = 4,
  parameter int PUSH_HOLD  = 10,
  parameter int SAMPLE_GAP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        adc_miso,
  input  logic        fifo_full,
  input  logic        ovr_clr,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [7:0]  dout,
  output logic        push_out,
  output logic [11:0] sample,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    PUSH     = 3'd4,
    GAP      = 3'd5
  } state_t;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HOLD_LAST = 16'(PUSH_HOLD - 1);
  localparam logic [15:0] GAP_LAST  = 16'(SAMPLE_GAP - 1);
  localparam logic [4:0]  BIT_LAST  = 5'd15;

  state_t      state_r, state_n;
  logic [15:0] cnt_r, cnt_n;
  logic [4:0]  bit_r, bit_n;
  logic [15:0] shift_r, shift_n;
  logic        cs_n_r, cs_n_n;
  logic        sclk_r, sclk_n;
  logic        push_r, push_n;
  logic [7:0]  dout_r, dout_n;
  logic [11:0] sample_r, sample_n;
  logic        ferr_r, ferr_n;
  logic        ovr_r, ovr_n;
  logic        busy_r;

  // State, counters, shift register and all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= 16'd0;
      bit_r    <= 5'd0;
      shift_r  <= 16'd0;
      cs_n_r   <= 1'b1;
      sclk_r   <= 1'b1;
      push_r   <= 1'b0;
      dout_r   <= 8'd0;
      sample_r <= 12'd0;
      ferr_r   <= 1'b0;
      ovr_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      cnt_r    <= cnt_n;
      bit_r    <= bit_n;
      shift_r  <= shift_n;
      cs_n_r   <= cs_n_n;
      sclk_r   <= sclk_n;
      push_r   <= push_n;
      dout_r   <= dout_n;
      sample_r <= sample_n;
      ferr_r   <= ferr_n;
      ovr_r    <= ovr_n;
      busy_r   <= (state_n != IDLE);
    end
  end

  // Next-state and next-output logic; outputs change on the edge that enters a phase.
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    bit_n    = bit_r;
    shift_n  = shift_r;
    cs_n_n   = cs_n_r;
    sclk_n   = sclk_r;
    push_n   = push_r;
    dout_n   = dout_r;
    sample_n = sample_r;
    ferr_n   = ferr_r;
    ovr_n    = ovr_r;

    // A drop in the same cycle overrides the clear (assigned later below).
    if (ovr_clr) begin
      ovr_n = 1'b0;
    end else begin
      ovr_n = ovr_r;
    end

    case (state_r)
      IDLE: begin
        if (en) begin
          state_n = CS_SETUP;
          cnt_n   = 16'd0;
          cs_n_n  = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      CS_SETUP: begin
        if (cnt_r == DIV_LAST) begin
          state_n = SHIFT;
          cnt_n   = 16'd0;
          bit_n   = 5'd0;
          sclk_n  = 1'b0;
        end else begin
          cnt_n = cnt_r + 16'd1;
        end
      end
      SHIFT: begin
        if (cnt_r != DIV_LAST) begin
          cnt_n = cnt_r + 16'd1;
        end else if (!sclk_r) begin
          // End of low phase: sclk rises and the ADC bit is captured together.
          cnt_n   = 16'd0;
          sclk_n  = 1'b1;
          shift_n = {shift_r[14:0], adc_miso};
        end else if (bit_r == BIT_LAST) begin
          state_n = CS_HOLD;
          cnt_n   = 16'd0;
          cs_n_n  = 1'b1;
        end else begin
          cnt_n  = 16'd0;
          bit_n  = bit_r + 5'd1;
          sclk_n = 1'b0;
        end
      end
      CS_HOLD: begin
        if (cnt_r == DIV_LAST) begin
          state_n  = PUSH;
          cnt_n    = 16'd0;
          sample_n = shift_r[11:0];
          dout_n   = shift_r[11:4];
          ferr_n   = |shift_r[15:12];
          // fifo_full is looked at only here, on the edge entering PUSH.
          if (fifo_full) begin
            ovr_n  = 1'b1;
            push_n = 1'b0;
          end else begin
            push_n = 1'b1;
          end
        end else begin
          cnt_n = cnt_r + 16'd1;
        end
      end
      PUSH: begin
        if (!push_r) begin
          state_n = GAP;
          cnt_n   = 16'd0;
        end else if (cnt_r == HOLD_LAST) begin
          state_n = GAP;
          cnt_n   = 16'd0;
          push_n  = 1'b0;
        end else begin
          cnt_n = cnt_r + 16'd1;
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          cnt_n = 16'd0;
          if (en) begin
            state_n = CS_SETUP;
            cs_n_n  = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt_r + 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 16'd0;
        bit_n   = 5'd0;
        cs_n_n  = 1'b1;
        sclk_n  = 1'b1;
        push_n  = 1'b0;
      end
    endcase
  end

  assign adc_cs_n  = cs_n_r;
  assign adc_sclk  = sclk_r;
  assign push_out  = push_r;
  assign dout      = dout_r;
  assign sample    = sample_r;
  assign frame_err = ferr_r;
  assign overrun   = ovr_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench for adc_spi_capture: ADC serial model, clk/10 FIFO model,
// per-scenario tasks with inline comparisons against hand-computed values.
module tb_adc_spi_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        adc_miso;
  logic        fifo_full;
  logic        ovr_clr;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic [7:0]  dout;
  logic        push_out;
  logic [11:0] sample;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int n_cmp = 0;
  int n_fail = 0;

  adc_spi_capture dut (
    .clk(clk), .rst_n(rst_n), .en(en), .adc_miso(adc_miso),
    .fifo_full(fifo_full), .ovr_clr(ovr_clr), .adc_cs_n(adc_cs_n),
    .adc_sclk(adc_sclk), .dout(dout), .push_out(push_out), .sample(sample),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // ADC model: word latched on CS fall, one bit presented per sclk fall.
  logic [15:0] adc_word = 16'h0000;
  logic [15:0] cur_word = 16'h0000;
  int          bit_idx = 15;
  int          frame_idx = 0;
  int          b2b_start = 0;
  logic        b2b = 1'b0;
  logic        full_force = 1'b0;

  always @(negedge adc_cs_n) begin
    if (b2b) cur_word = {4'h0, 12'h100 + 12'((frame_idx - b2b_start) * 16)};
    else     cur_word = adc_word;
    frame_idx = frame_idx + 1;
    bit_idx = 15;
  end

  always @(negedge adc_sclk) begin
    if (adc_cs_n === 1'b0 && bit_idx >= 0) begin
      adc_miso = cur_word[bit_idx];
      bit_idx = bit_idx - 1;
    end
  end

  // Edge monitors.
  int rise_cnt = 0;
  int push_rises = 0;
  always @(posedge adc_sclk) if (adc_cs_n === 1'b0) rise_cnt = rise_cnt + 1;
  always @(posedge push_out) push_rises = push_rises + 1;

  // FIFO model on a clk/10 clock; it only records during back-to-back mode.
  logic       fsclk = 1'b0;
  int         fdiv = 0;
  int         fcount = 0;
  int         fsamples = 0;
  logic [7:0] fifo_mem [16];

  always @(negedge clk) begin
    if (fdiv == 4) begin
      fdiv = 0;
      fsclk = ~fsclk;
    end else begin
      fdiv = fdiv + 1;
    end
  end

  always @(posedge fsclk) begin
    if (b2b && push_out === 1'b1) begin
      fsamples = fsamples + 1;
      if (fcount < 16) begin
        fifo_mem[fcount] = dout;
        fcount = fcount + 1;
      end
    end
  end

  assign fifo_full = b2b ? (fcount == 16) : full_force;

  // Frame recording (filled by capture_frame, compared by the test tasks).
  int sclk_low_at, cs_hi_at, push_first, push_last, push_cyc, cs_low_late;
  int rises, pushes;
  logic busy_at0;

  // Start one frame from IDLE and record its timing relative to T0.
  task automatic capture_frame(input logic [15:0] word, input int drop_at, input int clr_at);
    int waited;
    int r0;
    int p0;
    adc_word = word;
    r0 = rise_cnt;
    p0 = push_rises;
    sclk_low_at = -1; cs_hi_at = -1; push_first = -1; push_last = -1;
    push_cyc = 0; cs_low_late = 0; busy_at0 = 1'b0;
    @(negedge clk);
    en = 1'b1;
    waited = 0;
    @(negedge clk);
    while (adc_cs_n !== 1'b0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (adc_cs_n !== 1'b0) begin
      n_cmp++; n_fail++;
      $display("FAIL cs_start_timeout: adc_cs_n=%b, required 0 within 50 cycles", adc_cs_n);
      en = 1'b0;
      return;
    end
    busy_at0 = busy;
    for (int i = 0; i < 200; i++) begin
      if (adc_sclk === 1'b0 && sclk_low_at < 0) sclk_low_at = i;
      if (adc_cs_n === 1'b1 && cs_hi_at < 0) cs_hi_at = i;
      if (push_out === 1'b1) begin
        if (push_first < 0) push_first = i;
        push_last = i;
        push_cyc++;
      end
      if (i >= 160 && adc_cs_n !== 1'b1) cs_low_late++;
      if (i == drop_at) en = 1'b0;
      ovr_clr = (i == clr_at);
      @(negedge clk);
    end
    en = 1'b0;
    ovr_clr = 1'b0;
    rises = rise_cnt - r0;
    pushes = push_rises - p0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; ovr_clr = 1'b0; adc_miso = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (adc_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b want 1", adc_cs_n); end
    n_cmp++; if (adc_sclk !== 1'b1) begin n_fail++; $display("FAIL reset_sclk: got %b want 1", adc_sclk); end
    n_cmp++; if (push_out !== 1'b0) begin n_fail++; $display("FAIL reset_push: got %b want 0", push_out); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
    n_cmp++; if (sample !== 12'h000) begin n_fail++; $display("FAIL reset_sample: got %h want 000", sample); end
    n_cmp++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got ferr=%b ovr=%b want 0/0", frame_err, overrun);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (adc_cs_n !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_without_en: got cs_n=%b busy=%b want 1/0", adc_cs_n, busy);
    end
  endtask

  task automatic test_basic_frame();
    capture_frame(16'h0ABC, 100, -1);
    n_cmp++; if (busy_at0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy_at0); end
    n_cmp++; if (sclk_low_at != 4) begin n_fail++; $display("FAIL basic_sclk_fall: got T0+%0d want T0+4", sclk_low_at); end
    n_cmp++; if (cs_hi_at != 132) begin n_fail++; $display("FAIL basic_cs_rise: got T0+%0d want T0+132", cs_hi_at); end
    n_cmp++; if (push_first != 136 || push_last != 145 || push_cyc != 10) begin
      n_fail++; $display("FAIL basic_push: got %0d..%0d (%0d cyc) want 136..145 (10)", push_first, push_last, push_cyc);
    end
    n_cmp++; if (rises != 16) begin n_fail++; $display("FAIL basic_sclk_rises: got %0d want 16", rises); end
    n_cmp++; if (pushes != 1) begin n_fail++; $display("FAIL basic_push_count: got %0d want 1", pushes); end
    n_cmp++; if (sample !== 12'hABC) begin n_fail++; $display("FAIL basic_sample: got %h want abc", sample); end
    n_cmp++; if (dout !== 8'hAB) begin n_fail++; $display("FAIL basic_dout: got %h want ab", dout); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_ferr: got %b want 0", frame_err); end
  endtask

  task automatic test_frame_err();
    capture_frame(16'h8123, 100, -1);
    n_cmp++; if (sample !== 12'h123) begin n_fail++; $display("FAIL ferr_sample: got %h want 123", sample); end
    n_cmp++; if (dout !== 8'h12) begin n_fail++; $display("FAIL ferr_dout: got %h want 12", dout); end
    n_cmp++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %b want 1", frame_err); end
    n_cmp++; if (pushes != 1 || push_cyc != 10) begin
      n_fail++; $display("FAIL ferr_push: got %0d pushes %0d cyc want 1/10", pushes, push_cyc);
    end
  endtask

  task automatic test_en_drop();
    capture_frame(16'h0F0F, 20, -1);
    n_cmp++; if (cs_hi_at != 132) begin n_fail++; $display("FAIL endrop_complete: got cs rise T0+%0d want T0+132", cs_hi_at); end
    n_cmp++; if (pushes != 1) begin n_fail++; $display("FAIL endrop_push: got %0d want 1", pushes); end
    n_cmp++; if (sample !== 12'hF0F) begin n_fail++; $display("FAIL endrop_sample: got %h want f0f", sample); end
    n_cmp++; if (cs_low_late != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL endrop_idle: got %0d low cycles busy=%b want 0/0", cs_low_late, busy);
    end
  endtask

  task automatic test_reset_mid_shift();
    int waited;
    int p0;
    int lows;
    @(negedge clk);
    en = 1'b1;
    waited = 0;
    @(negedge clk);
    while (adc_cs_n !== 1'b0 && waited < 50) begin @(negedge clk); waited++; end
    repeat (60) @(negedge clk);
    n_cmp++; if (adc_cs_n !== 1'b0) begin n_fail++; $display("FAIL midrst_in_frame: got cs_n=%b want 0", adc_cs_n); end
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    n_cmp++; if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b1 || push_out !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: got cs_n=%b sclk=%b push=%b busy=%b want 1/1/0/0",
                         adc_cs_n, adc_sclk, push_out, busy);
    end
    n_cmp++; if (sample !== 12'h000 || dout !== 8'h00) begin
      n_fail++; $display("FAIL midrst_data: got sample=%h dout=%h want 000/00", sample, dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    p0 = push_rises;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      if (adc_cs_n !== 1'b1) lows++;
      @(negedge clk);
    end
    n_cmp++; if (push_rises - p0 != 0 || lows != 0) begin
      n_fail++; $display("FAIL midrst_quiet: got %0d pushes %0d cs-low cycles want 0/0", push_rises - p0, lows);
    end
  endtask

  task automatic test_overrun();
    full_force = 1'b1;
    capture_frame(16'h0ABC, 100, -1);
    n_cmp++; if (pushes != 0 || push_cyc != 0) begin
      n_fail++; $display("FAIL ovr_no_push: got %0d pushes %0d cyc want 0/0", pushes, push_cyc);
    end
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
    n_cmp++; if (sample !== 12'hABC) begin n_fail++; $display("FAIL ovr_sample: got %h want abc", sample); end
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    capture_frame(16'h0555, 100, 135);
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
    full_force = 1'b0;
  endtask

  task automatic test_back_to_back();
    int p0;
    int waited;
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_pre_clear: got %b want 0", overrun); end
    b2b_start = frame_idx;
    b2b = 1'b1;
    p0 = push_rises;
    en = 1'b1;
    for (int f = 0; f < 20; f++) begin
      waited = 0;
      while (adc_cs_n !== 1'b0 && waited < 400) begin @(negedge clk); waited++; end
      if (f == 19) en = 1'b0;
      waited = 0;
      while (adc_cs_n !== 1'b1 && waited < 400) begin @(negedge clk); waited++; end
      repeat (8) @(negedge clk);
      n_cmp++; if (overrun !== (f >= 16)) begin
        n_fail++; $display("FAIL b2b_overrun_f%0d: got %b want %b", f, overrun, (f >= 16));
      end
    end
    repeat (200) @(negedge clk);
    n_cmp++; if (fcount != 16 || fifo_full !== 1'b1) begin
      n_fail++; $display("FAIL b2b_fill: got %0d bytes full=%b want 16/1", fcount, fifo_full);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (fifo_mem[i] !== 8'(8'h10 + i)) begin
        n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, fifo_mem[i], 8'(8'h10 + i));
      end
    end
    n_cmp++; if (fsamples != 16 || push_rises - p0 != 16) begin
      n_fail++; $display("FAIL b2b_single_edge: got %0d fifo samples %0d pushes want 16/16", fsamples, push_rises - p0);
    end
    n_cmp++; if (busy !== 1'b0 || adc_cs_n !== 1'b1) begin
      n_fail++; $display("FAIL b2b_idle: got busy=%b cs_n=%b want 0/1", busy, adc_cs_n);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_frame_err();
    test_en_drop();
    test_reset_mid_shift();
    test_overrun();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
